div_32bit_seq: RTL and testbench

Multi-cycle unsigned restoring divider: the inverse-direction companion of the 32-bit ripple adder in the ALU datapath. It accepts a dividend and divisor on a start pulse and performs one trial subtraction per clock. It returns quotient and remainder with a one-cycle done pulse plus Z/N flags matching the adder's flag semantics. The block sits beside the adder in the ALU and serves the control unit's DIV/MOD operations.

---
 rtl/div_pkg.sv | 20 ++
 rtl/sub_nbit.sv | 24 ++
 rtl/div_32bit_seq.sv | 124 ++++++++++++
 tb/tb_div_32bit_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Default operand width, FSM state encoding and iteration-counter sizing.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  // Counter must reach WIDTH-1; keep at least one bit for tiny widths.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_nbit.sv
// N-bit ripple subtractor built from full-subtractor bit cells; purely combinational.
// diff = a - b - bin, bout set when the result went negative.
module sub_nbit #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] diff,
  output logic         bout
);

  logic [N:0] br;

  assign br[0] = bin;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign diff[i]  = a[i] ^ b[i] ^ br[i];
    assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end

  assign bout = br[N];

endmodule

// File: rtl/div_32bit_seq.sv
// Unsigned restoring divider, one trial subtraction per clock; latency WIDTH+1 edges (1 for /0).
// No backpressure: start is only honoured in IDLE, requests during CALC/DONE are dropped.
module div_32bit_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             Z,
  output logic             N
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             unused_trial_msb;

  // q starts as the dividend; its MSB shifts into the partial remainder each step.
  assign shifted = {rem, q[WIDTH-1]};

  sub_nbit #(
    .N (WIDTH + 1)
  ) u_sub (
    .a    (shifted),
    .b    ({1'b0, dvs}),
    .bin  (1'b0),
    .diff (trial),
    .bout (borrow)
  );

  // When there is no borrow the top bit of the difference is always zero.
  assign unused_trial_msb = trial[WIDTH];

  assign busy = (state == CALC);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      q           <= '0;
      dvs         <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      Z           <= 1'b0;
      N           <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q           <= dividend;
            dvs         <= divisor;
            rem         <= '0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          rem <= borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], ~borrow};
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          done <= 1'b1;
          if (dvs == '0) begin
            // q was never shifted, so it still holds the captured dividend.
            quotient    <= '1;
            remainder   <= q;
            div_by_zero <= 1'b1;
            Z           <= 1'b0;
            N           <= 1'b1;
          end else begin
            quotient  <= q;
            remainder <= rem;
            Z         <= (q == '0);
            N         <= (q != '0) & q[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32bit_seq.sv
// Bench for div_32bit_seq: directed literal cases plus randomized traffic against an arithmetic model.
module tb_div_32bit_seq;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          busy;
  logic          done;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          div_by_zero;
  logic          Z;
  logic          N;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  div_32bit_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .Z           (Z),
    .N           (N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request yields a/b, a%b after a fixed latency.
  logic [W-1:0] e_q, e_r;
  logic         e_dz, e_z, e_n, e_done, e_busy;
  logic [W-1:0] pa, pb;
  int           pend;

  initial begin
    e_q = '0; e_r = '0; e_dz = 0; e_z = 0; e_n = 0; e_done = 0; e_busy = 0;
    pa = '0; pb = '0; pend = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q = '0; e_r = '0; e_dz = 0; e_z = 0; e_n = 0; e_done = 0; e_busy = 0;
      pend = 0;
    end else begin
      e_done = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          e_done = 1;
          if (pb == 0) begin
            e_q = '1; e_r = pa; e_dz = 1; e_z = 0; e_n = 1;
          end else begin
            e_q = pa / pb; e_r = pa % pb; e_dz = 0;
            e_z = (e_q == 0);
            e_n = e_z ? 1'b0 : e_q[W-1];
          end
        end
      end else if (start) begin
        pa   = dividend;
        pb   = divisor;
        pend = (divisor == 0) ? 1 : W + 1;
        e_dz = 0;
      end
      e_busy = (pend >= 2);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, busy}, {31'b0, e_busy});
      chk("done", {31'b0, done}, {31'b0, e_done});
      chk("quotient", quotient, e_q);
      chk("remainder", remainder, e_r);
      chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e_dz});
      chk("Z", {31'b0, Z}, {31'b0, e_z});
      chk("N", {31'b0, N}, {31'b0, e_n});
      tests++;
      if (busy && done) begin
        fails++;
        $display("FAIL busy_and_done: both high at %0t", $time);
      end
    end
  end

  // Issues one request, optionally injecting a second start or a reset mid-flight.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj_at, input int rst_at,
                        output int lat, output int bcnt, output int dcnt);
    @(posedge clk) #2;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk) #2;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    lat = -1; bcnt = 0; dcnt = 0;
    for (int n = 1; n <= W + 10; n++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat < 0) lat = n - 1;
      end
      if (n == rst_at + 1) begin
        chk("rst_mid_q", quotient, '0);
        chk("rst_mid_r", remainder, '0);
        chk("rst_mid_busy", {31'b0, busy}, '0);
        chk("rst_mid_flags", {29'b0, div_by_zero, Z, N}, '0);
      end
      if (n == inj_at) begin
        start = 1'b1; dividend = 9; divisor = 3;
      end
      if (n == inj_at + 1) start = 1'b0;
      if (n == rst_at) #1 rst_n = 1'b0;
      if (n == rst_at + 2) #1 rst_n = 1'b1;
    end
  endtask

  int lat, bcnt, dcnt;

  initial begin
    rst_n = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #3 rst_n = 1'b0;
    chk_en = 1;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, '0);
    chk("reset_done", {31'b0, done}, '0);
    chk("reset_q", quotient, '0);
    chk("reset_r", remainder, '0);
    chk("reset_flags", {29'b0, div_by_zero, Z, N}, '0);
    @(posedge clk) #2 rst_n = 1'b1;

    run_op(32'd100, 32'd7, -5, -5, lat, bcnt, dcnt);
    chk("100/7_latency", lat, 33);
    chk("100/7_busy_cycles", bcnt, 32);
    chk("100/7_q", quotient, 32'd14);
    chk("100/7_r", remainder, 32'd2);
    chk("100/7_flags", {29'b0, div_by_zero, Z, N}, 3'b000);

    run_op(32'd5, 32'd0, -5, -5, lat, bcnt, dcnt);
    chk("5/0_latency", lat, 1);
    chk("5/0_busy_cycles", bcnt, 0);
    chk("5/0_q", quotient, 32'hFFFF_FFFF);
    chk("5/0_r", remainder, 32'd5);
    chk("5/0_flags", {29'b0, div_by_zero, Z, N}, 3'b101);

    run_op(32'd3, 32'd10, -5, -5, lat, bcnt, dcnt);
    chk("3/10_q", quotient, 32'd0);
    chk("3/10_r", remainder, 32'd3);
    chk("3/10_flags", {29'b0, div_by_zero, Z, N}, 3'b010);

    run_op(32'hFFFF_FFFF, 32'd1, -5, -5, lat, bcnt, dcnt);
    chk("max/1_q", quotient, 32'hFFFF_FFFF);
    chk("max/1_r", remainder, 32'd0);
    chk("max/1_flags", {29'b0, div_by_zero, Z, N}, 3'b001);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -5, -5, lat, bcnt, dcnt);
    chk("max/max_q", quotient, 32'd1);
    chk("max/max_r", remainder, 32'd0);

    run_op(32'd100, 32'd7, 10, -5, lat, bcnt, dcnt);
    chk("ignored_start_latency", lat, 33);
    chk("ignored_start_dones", dcnt, 1);
    chk("ignored_start_q", quotient, 32'd14);
    chk("ignored_start_r", remainder, 32'd2);

    run_op(32'd100, 32'd7, -5, 11, lat, bcnt, dcnt);
    chk("reset_abort_dones", dcnt, 0);
    chk("reset_abort_q", quotient, 32'd0);

    run_op(32'd9, 32'd3, -5, -5, lat, bcnt, dcnt);
    chk("9/3_latency", lat, 33);
    chk("9/3_q", quotient, 32'd3);
    chk("9/3_r", remainder, 32'd0);

    // Random traffic: frequent start pulses, many landing while the divider is busy.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk) #2;
      start    = ($urandom_range(0, 3) == 0);
      dividend = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 7))
        0:       divisor = '0;
        1, 2:    divisor = $urandom_range(1, 15);
        3:       divisor = dividend;
        4:       divisor = $urandom >> $urandom_range(0, 31);
        default: divisor = $urandom;
      endcase
    end
    @(posedge clk) #2 start = 1'b0;
    repeat (W + 4) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
